// File: rtl/julia_iter.sv
// Escape-time iteration engine: iterates z <- z^2 + c in signed fixed point, one step per clock.
// Optional macro JULIA_ITER_STATS_EN adds the 32-bit iter_cycles activity counter port.
module julia_iter #(
    parameter int unsigned W        = 18,
    parameter int unsigned FRAC     = 14,
    parameter int unsigned MAX_ITER = 12,
    parameter int unsigned TAG_W    = 17
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] z0_re,
    input  logic signed [W-1:0] z0_im,
    input  logic signed [W-1:0] c_re,
    input  logic signed [W-1:0] c_im,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [7:0]          out_value,
    output logic [TAG_W-1:0]    out_tag
`ifdef JULIA_ITER_STATS_EN
    ,
    output logic [31:0]         iter_cycles
`endif
);

    localparam int unsigned PW  = 2 * W;
    localparam int unsigned EW  = 2 * W + 1;
    localparam int unsigned CNW = 8;
    // Squared-magnitude escape threshold 4.0 at the product scale 2^(2*FRAC).
    localparam logic signed [EW-1:0] ESC_LIM = EW'(64'd4 << (2 * FRAC));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic signed [W-1:0]    zr_q, zr_d, zi_q, zi_d;
    logic signed [W-1:0]    cr_q, cr_d, ci_q, ci_d;
    logic [TAG_W-1:0]       tag_q, tag_d;
    logic [CNW-1:0]         count_q, count_d;
    logic [CNW-1:0]         out_value_q, out_value_d;
    logic [TAG_W-1:0]       out_tag_q, out_tag_d;

    logic signed [PW-1:0]   rr_c, ii_c, ri_c;
    logic signed [EW-1:0]   mag_c, diff_c, ri2_c;
    logic                   escape_c;

    // Full-precision products and escape test on the current z.
    always_comb begin
        rr_c     = PW'(zr_q) * PW'(zr_q);
        ii_c     = PW'(zi_q) * PW'(zi_q);
        ri_c     = PW'(zr_q) * PW'(zi_q);
        mag_c    = EW'(rr_c) + EW'(ii_c);
        diff_c   = EW'(rr_c) - EW'(ii_c);
        ri2_c    = EW'(ri_c) + EW'(ri_c);
        escape_c = (mag_c > ESC_LIM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            zr_q        <= '0;
            zi_q        <= '0;
            cr_q        <= '0;
            ci_q        <= '0;
            tag_q       <= '0;
            count_q     <= '0;
            out_value_q <= '0;
            out_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            zr_q        <= zr_d;
            zi_q        <= zi_d;
            cr_q        <= cr_d;
            ci_q        <= ci_d;
            tag_q       <= tag_d;
            count_q     <= count_d;
            out_value_q <= out_value_d;
            out_tag_q   <= out_tag_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        zr_d        = zr_q;
        zi_d        = zi_q;
        cr_d        = cr_q;
        ci_d        = ci_q;
        tag_d       = tag_q;
        count_d     = count_q;
        out_value_d = out_value_q;
        out_tag_d   = out_tag_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    zr_d    = z0_re;
                    zi_d    = z0_im;
                    cr_d    = c_re;
                    ci_d    = c_im;
                    tag_d   = in_tag;
                    count_d = '0;
                    state_d = ITER;
                end
            end
            ITER: begin
                if (escape_c) begin
                    out_value_d = count_q;
                    out_tag_d   = tag_q;
                    state_d     = DONE;
                end else if (count_q == CNW'(MAX_ITER)) begin
                    out_value_d = CNW'(MAX_ITER);
                    out_tag_d   = tag_q;
                    state_d     = DONE;
                end else begin
                    // Truncating shifts and W-bit wrap are the defined arithmetic.
                    zr_d    = W'(diff_c >>> FRAC) + cr_q;
                    zi_d    = W'(ri2_c >>> FRAC) + ci_q;
                    count_d = count_q + CNW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign out_value = out_value_q;
    assign out_tag   = out_tag_q;

`ifdef JULIA_ITER_STATS_EN
    logic [31:0] iter_cycles_q;

    // Counts every clock spent iterating, independent of the handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            iter_cycles_q <= '0;
        end else if (state_q == ITER) begin
            iter_cycles_q <= iter_cycles_q + 32'd1;
        end
    end

    assign iter_cycles = iter_cycles_q;
`endif

endmodule
